// File: rtl/uart_pkg.sv
// Shared UART constants and the TX arbiter FSM encoding.
package uart_pkg;

    localparam int NDATA_BITS_DEF = 8;
    localparam int OVERSAMPLING   = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCEPT    = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above i_ptr,
// wrapping around, returned one-hot.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    logic          w_found;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;

    // i_ptr < N and off < N, so one conditional subtract is a full modulo
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int off = 0; off < N; off++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(off);
            if (w_sum >= (PW+1)'(N)) begin
                w_idx = PW'(w_sum - (PW+1)'(N));
            end else begin
                w_idx = PW'(w_sum);
            end
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among NREQ producers.
// Define UART_TX_ARB_LOCK_EN to hold the grant until a byte with last=1.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int NDATA_BITS = NDATA_BITS_DEF
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NREQ-1:0]            i_req_valid,
    input  logic [NREQ*NDATA_BITS-1:0] i_req_data,
    input  logic [NREQ-1:0]            i_req_last,
    output logic [NREQ-1:0]            o_req_ready,
    output logic [NREQ-1:0]            o_grant,
    output logic                       o_tx_start,
    output logic [NDATA_BITS-1:0]      o_tx_data,
    input  logic                       i_tx_ready,
    output logic                       o_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [NREQ-1:0]         r_grant;
    logic [NREQ-1:0]         w_pick;
    logic [PW-1:0]           r_ptr;
    logic [PW-1:0]           w_gidx;
    logic [PW-1:0]           w_ptr_nxt;
    logic [NDATA_BITS-1:0]   r_tx_data;
    logic [NDATA_BITS-1:0]   w_sel_data;
    logic                    w_sel_valid;
    logic                    w_arb;
    logic                    w_capture;
    logic                    w_drop;
    logic                    w_release;

    rr_picker #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    always_comb begin
        w_sel_data = '0;
        w_gidx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant[k]) begin
                w_sel_data = w_sel_data
                           | i_req_data[k*NDATA_BITS +: NDATA_BITS];
                w_gidx     = PW'(k);
            end
        end
    end

    assign w_sel_valid = |(i_req_valid & r_grant);
    assign w_ptr_nxt   = ({1'b0, w_gidx} == (PW+1)'(NREQ - 1))
                       ? '0 : w_gidx + 1'b1;

`ifdef UART_TX_ARB_LOCK_EN
    logic r_last;
    logic w_sel_last;

    assign w_sel_last = |(i_req_last & r_grant);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last <= 1'b0;
        end else if (w_capture) begin
            r_last <= w_sel_last;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^i_req_last;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        w_release   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (|i_req_valid) begin
                    w_arb       = 1'b1;
                    w_state_nxt = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (w_sel_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_LAUNCH;
                end else begin
                    w_drop      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (i_tx_ready) w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!i_tx_ready) w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_tx_ready) begin
`ifdef UART_TX_ARB_LOCK_EN
                    if (!r_last) begin
                        w_state_nxt = ST_ACCEPT;
                    end else begin
                        w_release   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
`else
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_ptr     <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arb) r_grant <= w_pick;
            if (w_drop) r_grant <= '0;
            if (w_release) begin
                r_grant <= '0;
                r_ptr   <= w_ptr_nxt;
            end
            if (w_capture) r_tx_data <= w_sel_data;
        end
    end

    assign o_grant     = r_grant;
    assign o_req_ready = (r_state == ST_ACCEPT) ? r_grant : '0;
    assign o_tx_start  = (r_state == ST_LAUNCH) && i_tx_ready;
    assign o_tx_data   = r_tx_data;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed steps plus random traffic,
// checked against a round-robin reference and a transmitter model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ       (4),
        .NDATA_BITS (8)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_grant     (grant),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] q_d [4][$];
    bit         q_l [4][$];
    logic [7:0] log_q [$];
    bit         force_drop [4];
    bit         tx_hold  = 1'b0;
    int         tx_cnt   = 0;
    logic       nx_ready = 1'b1;
    bit         model_on = 1'b0;

    logic [3:0] s_grant, s_rdy;
    logic       s_start, s_busy, s_txr;
    logic [7:0] s_data;

    logic [3:0] prev_grant = '0;
    logic [3:0] prev_valid = '0;
    logic       prev_busy  = 1'b0;
    logic       prev_txr   = 1'b1;
    int         m_ptr      = 0;
    bit         started    = 1'b0;
    logic [7:0] acc_byte   = '0;
    logic [7:0] exp_data   = '0;

    int cyc_n = 0;
    int n_starts = 0;
    int last_rdy_cyc, last_start_cyc, txr_rise_cyc;
    int busy_fall_cyc, grant_rise_cyc;
    logic [3:0] last_rdy_vec, last_grant_vec;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [3:0] v, input int p);
        for (int off = 0; off < 4; off++) begin
            if (v[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return 0;
    endfunction

    task automatic push(input int k, input logic [7:0] d, input bit l);
        q_d[k].push_back(d);
        q_l[k].push_back(l);
    endtask

    task automatic apply();
        for (int k = 0; k < 4; k++) begin
            req_valid[k] = (q_d[k].size() > 0) && !force_drop[k];
            req_data[k*8 +: 8] = (q_d[k].size() > 0) ? q_d[k][0] : 8'h00;
            req_last[k] = (q_l[k].size() > 0) ? q_l[k][0] : 1'b0;
        end
        tx_ready = nx_ready;
    endtask

    task automatic observe();
        int k;
        cyc_n++;
        s_grant = grant;
        s_rdy   = req_ready;
        s_start = tx_start;
        s_data  = tx_data;
        s_busy  = busy;
        s_txr   = tx_ready;
        if (model_on) begin
            chk("busy_vs_grant", s_busy, |s_grant);
            chk("tx_data_hold", s_data, exp_data);
            if (s_rdy != 0) chk("ready_is_grant", s_rdy, s_grant);
            if (prev_grant == 0 && s_grant != 0) begin
                chk("rr_grant", s_grant, 4'b0001 << rr(prev_valid, m_ptr));
                last_grant_vec = s_grant;
                grant_rise_cyc = cyc_n;
            end
            if (s_start) begin
                chk("start_needs_ready", s_txr, 1'b1);
                chk("start_data", s_data, acc_byte);
                log_q.push_back(s_data);
                n_starts++;
                last_start_cyc = cyc_n;
                started = 1'b1;
            end
        end
        if (s_rdy != 0) begin
            last_rdy_cyc = cyc_n;
            last_rdy_vec = s_rdy;
            started = 1'b0;
            k = oh2i(s_rdy);
            if (req_valid[k] && q_d[k].size() > 0) begin
                acc_byte = q_d[k].pop_front();
                void'(q_l[k].pop_front());
                exp_data = acc_byte;
            end
        end
        if (prev_grant != 0 && s_grant == 0 && started) begin
            m_ptr = (oh2i(prev_grant) + 1) % 4;
            started = 1'b0;
        end
        if (prev_busy && !s_busy) busy_fall_cyc = cyc_n;
        if (s_txr && !prev_txr) txr_rise_cyc = cyc_n;
        if (tx_hold) begin
            nx_ready = 1'b0;
            tx_cnt = 1;
        end else if (s_txr && s_start) begin
            nx_ready = 1'b0;
            tx_cnt = $urandom_range(6, 2);
        end else if (!s_txr) begin
            if (tx_cnt <= 1) nx_ready = 1'b1;
            else tx_cnt--;
        end
        prev_grant = s_grant;
        prev_valid = req_valid;
        prev_busy  = s_busy;
        prev_txr   = s_txr;
        if (rst) begin
            m_ptr      = 0;
            prev_grant = '0;
            started    = 1'b0;
            exp_data   = '0;
            nx_ready   = 1'b1;
            tx_cnt     = 0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic wait_idle(input int lim, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            cyc();
            if (q_d[0].size() == 0 && q_d[1].size() == 0 &&
                q_d[2].size() == 0 && q_d[3].size() == 0 &&
                !s_busy && s_txr) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, ok, 1'b1);
    endtask

    initial begin
        int t0, base, n0, k, len;
        bit found;
        logic [7:0] b;
        logic [7:0] exp_lock [4];
        int npush;

        rst = 1'b1;
        apply();
        repeat (3) cyc();
        chk("rst_grant", s_grant, 4'h0);
        chk("rst_ready", s_rdy, 4'h0);
        chk("rst_start", s_start, 1'b0);
        chk("rst_data", s_data, 8'h00);
        chk("rst_busy", s_busy, 1'b0);
        model_on = 1'b1;
        rst = 1'b0;
        cyc();

        // single requester timing
        push(1, 8'hA5, 1'b1);
        cyc();
        t0 = cyc_n + 1;
        wait_idle(60, "single_idle");
        chk("single_grant_cyc", grant_rise_cyc - t0, 1);
        chk("single_grant_vec", last_grant_vec, 4'b0010);
        chk("single_rdy_cyc", last_rdy_cyc - t0, 1);
        chk("single_rdy_vec", last_rdy_vec, 4'b0010);
        chk("single_start_cyc", last_start_cyc - t0, 2);
        chk("single_start_data", log_q[log_q.size()-1], 8'hA5);
        chk("single_busy_fall", busy_fall_cyc - txr_rise_cyc, 1);

        // all four continuously valid
        do_reset();
        base = log_q.size();
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 4; j++) push(j, 8'h10 + 8'(j), 1'b1);
        wait_idle(400, "rr4_idle");
        chk("rr4_count", log_q.size() - base, 12);
        for (int i = 0; i < 12; i++)
            chk("rr4_order", log_q[base+i], 8'h10 + 8'(i % 4));

        // packet lock versus per-byte arbitration
        do_reset();
        base = log_q.size();
        push(0, 8'hA0, 1'b0);
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b1);
        push(2, 8'hB0, 1'b1);
`ifdef UART_TX_ARB_LOCK_EN
        exp_lock = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
`else
        exp_lock = '{8'hA0, 8'hB0, 8'hA1, 8'hA2};
`endif
        wait_idle(200, "lock_idle");
        chk("lock_count", log_q.size() - base, 4);
        for (int i = 0; i < 4; i++)
            chk("lock_order", log_q[base+i], exp_lock[i]);

        // transmitter not ready while in LAUNCH
        tx_hold = 1'b1;
        cyc();
        push(3, 8'hC3, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (s_rdy != 0) begin
                found = 1'b1;
                break;
            end
        end
        chk("stall_accept", found, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("stall_no_start", s_start, 1'b0);
            chk("stall_data", s_data, 8'hC3);
        end
        n0 = n_starts;
        tx_hold = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (s_start) begin
                found = 1'b1;
                break;
            end
        end
        chk("stall_start_seen", found, 1'b1);
        chk("stall_start_cyc", last_start_cyc, txr_rise_cyc);
        wait_idle(60, "stall_idle");
        chk("stall_one_start", n_starts - n0, 1);

        // reset while waiting for the frame to finish
        do_reset();
        push(2, 8'hD2, 1'b1);
        wait_idle(60, "wd_pre_idle");
        push(3, 8'hE3, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (s_busy && !s_txr) begin
                found = 1'b1;
                break;
            end
        end
        chk("wd_reach", found, 1'b1);
        rst = 1'b1;
        cyc();
        chk("wd_busy_before", s_busy, 1'b1);
        rst = 1'b0;
        cyc();
        chk("wd_rst_grant", s_grant, 4'h0);
        chk("wd_rst_ready", s_rdy, 4'h0);
        chk("wd_rst_start", s_start, 1'b0);
        chk("wd_rst_data", s_data, 8'h00);
        chk("wd_rst_busy", s_busy, 1'b0);
        base = log_q.size();
        push(0, 8'hF0, 1'b1);
        push(3, 8'hF3, 1'b1);
        wait_idle(100, "wd_post_idle");
        chk("wd_post_grant", log_q[base], 8'hF0);
        chk("wd_post_second", log_q[base+1], 8'hF3);

        // valid withdrawn during ACCEPT
        push(1, 8'h5A, 1'b1);
        cyc();
        force_drop[1] = 1'b1;
        cyc();
        cyc();
        chk("viol_grant", s_grant, 4'b0010);
        chk("viol_ready", s_rdy, 4'b0010);
        n0 = n_starts;
        repeat (6) cyc();
        chk("viol_no_start", n_starts - n0, 0);
        chk("viol_grant_clr", s_grant, 4'h0);
        chk("viol_idle", s_busy, 1'b0);
        force_drop[1] = 1'b0;
        q_d[1].delete();
        q_l[1].delete();
        cyc();

        // random traffic
        do_reset();
        n0 = n_starts;
        npush = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5, 0) == 0) begin
                k = $urandom_range(3, 0);
                if (q_d[k].size() == 0) begin
                    len = $urandom_range(3, 1);
                    for (int j = 0; j < len; j++) begin
                        b = 8'($urandom);
                        push(k, b, j == len - 1);
                        npush++;
                    end
                end
            end
            cyc();
        end
        wait_idle(600, "rand_idle");
        chk("rand_count", n_starts - n0, npush);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
